dm_dma: RTL and testbench

//  Bus initiator for the data-memory/GPIO port (dm_w/dm_r/addr/wdata/dm_op/rdata).

---
 rtl/dm_dma.sv | 200 ++++++++++++++++++++
 tb/tb_dm_dma.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dma.sv
// dm_dma: single-channel word-copy DMA initiator for the data-memory/GPIO port.
// Each word is a one-cycle read strobe followed by a one-cycle write strobe.
// The word count, address stepping and abort handling are all done here.
`ifndef DM_OP_WD
`define DM_OP_WD 3'b011
`endif

module dm_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             src_inc,
    input  logic             dst_inc,
    input  logic             abort,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             dm_w,
    output logic             dm_r,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    output logic [2:0]       dm_op,
    input  logic [31:0]      rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
    logic             bus_req_q, bus_req_d;
    logic             dm_w_q, dm_w_d, dm_r_q, dm_r_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [LEN_W-1:0] words_done_q, words_done_d;

    logic [31:0]      src_nxt, dst_nxt;
    logic [LEN_W-1:0] wd_nxt;

    // Next-state logic: every output is decided one cycle ahead and registered.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        src_inc_d    = src_inc_q;
        dst_inc_d    = dst_inc_q;
        bus_req_d    = bus_req_q;
        dm_w_d       = 1'b0;
        dm_r_d       = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        words_done_d = words_done_q;

        src_nxt = src_inc_q ? src_q + 32'd4 : src_q;
        dst_nxt = dst_inc_q ? dst_q + 32'd4 : dst_q;
        wd_nxt  = words_done_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (len == '0) begin
                        err_d        = 1'b0;
                        done_d       = 1'b1;
                        words_done_d = '0;
                    end else begin
                        src_d        = src;
                        dst_d        = dst;
                        len_d        = len;
                        src_inc_d    = src_inc;
                        dst_inc_d    = dst_inc;
                        err_d        = 1'b0;
                        words_done_d = '0;
                        bus_req_d    = 1'b1;
                        busy_d       = 1'b1;
                        // With the grant already present the first read issues immediately.
                        if (bus_gnt) begin
                            state_d = S_RD;
                            dm_r_d  = 1'b1;
                            addr_d  = src;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (bus_gnt) begin
                    state_d = S_RD;
                    dm_r_d  = 1'b1;
                    addr_d  = src_q;
                end
            end
            S_RD: begin
                // rdata was loaded by the responder at the mid-cycle negedge.
                wdata_d = rdata;
                if (abort) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    // A word in flight always completes its write, grant or not.
                    state_d = S_WR;
                    dm_w_d  = 1'b1;
                    addr_d  = dst_q;
                end
            end
            default: begin
                words_done_d = wd_nxt;
                src_d        = src_nxt;
                dst_d        = dst_nxt;
                if (wd_nxt == len_q || abort) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (bus_gnt) begin
                    state_d = S_RD;
                    dm_r_d  = 1'b1;
                    addr_d  = src_nxt;
                end else begin
                    state_d = S_REQ;
                end
            end
        endcase
    end

    // State and output registers; reset drops the strobes without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            src_inc_q    <= 1'b0;
            dst_inc_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            dm_w_q       <= 1'b0;
            dm_r_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            src_inc_q    <= src_inc_d;
            dst_inc_q    <= dst_inc_d;
            bus_req_q    <= bus_req_d;
            dm_w_q       <= dm_w_d;
            dm_r_q       <= dm_r_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_done_q <= words_done_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign dm_w       = dm_w_q;
    assign dm_r       = dm_r_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign dm_op      = `DM_OP_WD;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_dm_dma.sv
// Scoreboard bench for dm_dma: expected reads, writes and completions are queued
// by the stimulus and retired by a monitor watching the bus at each negedge.
`ifndef DM_OP_WD
`define DM_OP_WD 3'b011
`endif

module tb_dm_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] len = '0;
    logic        src_inc = 1'b0, dst_inc = 1'b0, abort = 1'b0;
    logic        bus_req, bus_gnt = 1'b0;
    logic        dm_w, dm_r;
    logic [31:0] addr, wdata;
    logic [2:0]  dm_op;
    logic [31:0] rdata = '0;
    logic        busy, done, err;
    logic [15:0] words_done;

    logic [31:0] mem [0:255];
    logic [31:0] switches = 32'h0000_00A5;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic e; logic [15:0] wd; logic chk_wd; } dn_t;
    wr_t         exp_wr [$];
    logic [31:0] exp_rd [$];
    dn_t         exp_dn [$];

    int nvec = 0;
    int nerr = 0;

    dm_dma #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .src_inc(src_inc), .dst_inc(dst_inc), .abort(abort), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .dm_w(dm_w), .dm_r(dm_r), .addr(addr), .wdata(wdata),
        .dm_op(dm_op), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .words_done(words_done)
    );

    always #5 clk = ~clk;

    // Responder: RAM below 0x400, switch register at 0xbf800004.
    always @(negedge clk) begin
        if (dm_r) rdata <= (addr == 32'hbf80_0004) ? switches : mem[addr[9:2]];
    end

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_dat;
        else if (dm_w && !rst) mem[addr[9:2]] <= wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: retire queued expectations as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (dm_r && dm_w) chk("strobe_overlap", 32'd1, 32'd0);
            if (dm_r) begin
                if (exp_rd.size() == 0) chk("unexpected_rd", addr, 32'hFFFF_FFFF);
                else chk("rd_addr", addr, exp_rd.pop_front());
            end
            if (dm_w) begin
                if (exp_wr.size() == 0) chk("unexpected_wr", addr, 32'hFFFF_FFFF);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", addr, w.a);
                    chk("wr_data", wdata, w.d);
                end
            end
            if (done) begin
                if (exp_dn.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    dn_t x;
                    x = exp_dn.pop_front();
                    chk("done_err", {31'd0, err}, {31'd0, x.e});
                    if (x.chk_wd) chk("done_words", {16'd0, words_done}, {16'd0, x.wd});
                end
            end
        end
    end

    task automatic poke(input logic [7:0] i, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = i; pre_dat = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] l, input logic si, input logic di);
        @(negedge clk);
        src = s; dst = d; len = l; src_inc = si; dst_inc = di; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a; w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_dn(input logic e, input logic [15:0] wd, input logic c);
        dn_t x;
        x.e = e; x.wd = wd; x.chk_wd = c;
        exp_dn.push_back(x);
    endtask

    // Cycles from the accepting posedge until done is seen (called #1 after that edge).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_dmw();
        int n;
        n = 0;
        while (!dm_w && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!dm_w) chk("dmw_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        repeat (2) @(posedge clk);
        #1;
        chk(name, exp_rd.size() + exp_wr.size() + exp_dn.size(), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        for (int i = 0; i < 256; i++) pre_dat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_r", {31'd0, dm_r}, 32'd0);
        chk("rst_dm_w", {31'd0, dm_w}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_dm_op", {29'd0, dm_op}, {29'd0, `DM_OP_WD});
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 16; i++) poke(i[7:0], 32'hA0A0_0000 + i);
        poke(8'hC0, 32'h5555_5555);
        poke(8'h82, 32'hDEAD_BEEF);
        poke(8'h90, 32'h1234_5678);
        bus_gnt = 1'b1;

        // 1: RAM-to-RAM copy
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(32'h0 + 4 * i);
            push_wr(32'h40 + 4 * i, 32'hA0A0_0000 + i);
        end
        push_dn(1'b0, 16'd4, 1'b1);
        start_xfer(32'h0, 32'h40, 16'd4, 1'b1, 1'b1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("copy_latency", n, 32'd8);
        drain("copy_queues");
        for (int i = 0; i < 4; i++) chk("copy_mem", mem[8'h10 + i], 32'hA0A0_0000 + i);
        chk("copy_words_done", {16'd0, words_done}, 32'd4);
        chk("copy_idle_busy", {31'd0, busy}, 32'd0);

        // 2: fixed-address GPIO poll into RAM
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(32'hbf80_0004);
            push_wr(32'h80 + 4 * i, 32'h0000_00A5);
        end
        push_dn(1'b0, 16'd3, 1'b1);
        start_xfer(32'hbf80_0004, 32'h80, 16'd3, 1'b0, 1'b1);
        wait_done(n);
        drain("gpio_queues");
        chk("gpio_mem2", mem[8'h22], 32'h0000_00A5);

        // 3: misaligned source, then a good start clears err
        push_dn(1'b1, 16'd0, 1'b0);
        start_xfer(32'h2, 32'h100, 16'd5, 1'b1, 1'b1);
        wait_done(n);
        chk("misalign_latency", n, 32'd0);
        drain("misalign_queues");
        chk("err_sticky", {31'd0, err}, 32'd1);
        exp_rd.push_back(32'h0);
        push_wr(32'h100, 32'hA0A0_0000);
        push_dn(1'b0, 16'd1, 1'b1);
        start_xfer(32'h0, 32'h100, 16'd1, 1'b1, 1'b1);
        wait_done(n);
        drain("errclr_queues");
        chk("err_cleared", {31'd0, err}, 32'd0);

        // 4: zero length, then a start while busy is ignored
        push_dn(1'b0, 16'd0, 1'b1);
        start_xfer(32'h0, 32'h140, 16'd0, 1'b1, 1'b1);
        wait_done(n);
        chk("len0_latency", n, 32'd0);
        drain("len0_queues");
        for (int i = 0; i < 2; i++) begin
            exp_rd.push_back(32'h0 + 4 * i);
            push_wr(32'h140 + 4 * i, 32'hA0A0_0000 + i);
        end
        push_dn(1'b0, 16'd2, 1'b1);
        start_xfer(32'h0, 32'h140, 16'd2, 1'b1, 1'b1);
        start_xfer(32'h8, 32'h300, 16'd1, 1'b1, 1'b1);
        wait_done(n);
        drain("busy_start_queues");
        chk("ignored_dst_mem", mem[8'hC0], 32'h5555_5555);

        // 5: grant withheld at start, then dropped during the first write
        bus_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(32'h0 + 4 * i);
            push_wr(32'h180 + 4 * i, 32'hA0A0_0000 + i);
        end
        push_dn(1'b0, 16'd3, 1'b1);
        start_xfer(32'h0, 32'h180, 16'd3, 1'b1, 1'b1);
        repeat (3) begin
            chk("nognt_strobes", {30'd0, dm_r, dm_w}, 32'd0);
            chk("nognt_bus_req", {31'd0, bus_req}, 32'd1);
            @(posedge clk); #1;
        end
        bus_gnt = 1'b1;
        wait_dmw();
        bus_gnt = 1'b0;
        @(posedge clk); #1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_strobes", {30'd0, dm_r, dm_w}, 32'd0);
        end
        bus_gnt = 1'b1;
        wait_done(n);
        drain("grant_queues");
        chk("grant_mem2", mem[8'h62], 32'hA0A0_0002);

        // 6: abort during the read of word 3
        for (int i = 0; i < 3; i++) exp_rd.push_back(32'h0 + 4 * i);
        push_wr(32'h200, 32'hA0A0_0000);
        push_wr(32'h204, 32'hA0A0_0001);
        push_dn(1'b0, 16'd2, 1'b1);
        start_xfer(32'h0, 32'h200, 16'd8, 1'b1, 1'b1);
        cnt = 1;
        n = 0;
        while (cnt < 3 && n < 200) begin
            @(posedge clk); #1; n++;
            if (dm_r) cnt++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(n);
        drain("abort_queues");
        chk("abort_words_done", {16'd0, words_done}, 32'd2);
        chk("abort_mem_untouched", mem[8'h82], 32'hDEAD_BEEF);

        // 6b: asynchronous reset while a write strobe is up
        exp_rd.push_back(32'h0);
        start_xfer(32'h0, 32'h240, 16'd4, 1'b1, 1'b1);
        wait_dmw();
        rst = 1'b1;
        #1;
        chk("arst_strobes", {30'd0, dm_r, dm_w}, 32'd0);
        chk("arst_flags", {28'd0, bus_req, busy, done, err}, 32'd0);
        chk("arst_words_done", {16'd0, words_done}, 32'd0);
        chk("arst_wdata", wdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        drain("arst_queues");
        chk("arst_mem_untouched", mem[8'h90], 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
